clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the divide-ratio and counter.
REQ-002 The block SHALL have parameter DIV_INIT, default 8, giving the divide ratio loaded at reset.
REQ-003 Port clk_100  input  1  sole system clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port run  input  1  level request to generate clk_out.
REQ-006 Port cfg_valid  input  1  new divide ratio offered.
REQ-007 Port cfg_ratio  input  CNT_W  offered divide ratio N.
REQ-008 Port cfg_ready  output  1  block can accept a ratio this cycle.
REQ-009 Port clk_out  output  1  registered divided clock.
REQ-010 Port period_tick  output  1  one-cycle pulse marking the first cycle of each clk_out period.
REQ-011 Port cur_ratio  output  CNT_W  ratio currently in force.
REQ-012 Port cfg_err  output  1  one-cycle pulse on a rejected ratio (CLK_DIV_CFG_CHK_EN only; tied 0 otherwise).

Function
REQ-013 The FSM SHALL have states IDLE, RUN and PEND (RUN with a ratio update waiting).
REQ-014 In RUN and PEND, the registers cnt and clk_out SHALL update together, with clk_out = 1 exactly when cnt < cur_ratio/2 (integer division): high N/2 cycles, low N-N/2 cycles.
REQ-015 cnt SHALL count 0..cur_ratio-1 and wrap to 0, and period_tick SHALL be 1 exactly when cnt==0 in RUN or PEND.
REQ-016 IDLE with run=1 SHALL go to RUN on the next edge with cnt=0, clk_out=1 and period_tick=1.
REQ-017 cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND, and a transfer SHALL occur when cfg_valid and cfg_ready are both 1.
REQ-018 A transfer in IDLE SHALL set cur_ratio on the next edge.
REQ-019 A transfer in RUN SHALL latch the ratio into a pending register and go to PEND, leaving cur_ratio unchanged.
REQ-020 In PEND, on the boundary cycle (cnt==cur_ratio-1), the next edge SHALL load cur_ratio from pending, set cnt=0 and clk_out=1, and return to RUN, so that no truncated or stretched phase appears.
REQ-021 When run=0 in RUN or PEND, the block SHALL finish the current period and, on the boundary edge, enter IDLE with cnt=0 and clk_out=0, applying any pending ratio on that edge.
REQ-022 If run returns to 1 before the boundary, operation SHALL continue without interruption.
REQ-023 In IDLE, clk_out and period_tick SHALL be 0.
REQ-024 A transfer and a boundary in the same cycle in RUN SHALL take the PEND path, so the new ratio applies at the following boundary.

Reset
REQ-025 While rst_n=0: state=IDLE, cnt=0, clk_out=0, period_tick=0, cfg_err=0, cur_ratio=DIV_INIT, pending=DIV_INIT, cfg_ready=1.
REQ-026 Reset mid-period SHALL abort immediately (asynchronous) and discard any pending ratio, with operation resuming per REQ-016 after release.

Configuration
REQ-027 With CLK_DIV_CFG_CHK_EN defined, cfg_ratio<2 SHALL be consumed (cfg_ready handshake completes), leave cur_ratio, pending and state unchanged, and pulse cfg_err for one cycle.
REQ-028 Without CLK_DIV_CFG_CHK_EN, cfg_ratio<2 SHALL be clamped to 2 and cfg_err SHALL be constant 0.

Verification
REQ-029 Reset, then run=1 with defaults -> clk_out repeats 4 high / 4 low, and period_tick pulses every 8 cycles, first on the cycle after run is sampled.
REQ-030 In IDLE, cfg_ratio=5 is transferred, then run=1 -> cur_ratio=5 on the next cycle; clk_out repeats 2 high / 3 low.
REQ-031 While running N=8, cfg_ratio=4 arrives at cnt=2 -> cfg_ready=0 until the boundary; the current period completes 8 cycles; the next periods are 2 high / 2 low.
REQ-032 While running N=8, run drops at cnt=1 -> clk_out completes 4 high / 4 low, then stays 0; state=IDLE; no period_tick follows.
REQ-033 cfg_ratio=1 -> with the macro, cfg_err pulses and cur_ratio is unchanged; without it, cur_ratio=2 and clk_out toggles every cycle.
REQ-034 rst_n asserted at cnt=3 with a pending ratio -> outputs immediately take reset values, and after release cur_ratio=DIV_INIT.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: clk_out is high N/2 and low N-N/2 cycles of clk_100, ratio changes only at period boundaries.
// Define CLK_DIV_CFG_CHK_EN to reject ratios below 2 with a cfg_err pulse instead of clamping them to 2.
module clk_div_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 8
) (
  input  logic             clk_100,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             period_tick,
  output logic [CNT_W-1:0] cur_ratio,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [CNT_W-1:0] INIT = CNT_W'(DIV_INIT);
  localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             xfer, acc, boundary;
  logic [CNT_W-1:0] acc_val;

  assign cfg_ready = (state_q != PEND);
  assign xfer      = cfg_valid && cfg_ready;
  assign boundary  = (cnt_q == ratio_q - ONE);

`ifdef CLK_DIV_CFG_CHK_EN
  // Rejected ratios still complete the handshake so the producer is not stalled.
  assign acc     = xfer && (cfg_ratio >= TWO);
  assign acc_val = cfg_ratio;
  assign err_d   = xfer && (cfg_ratio < TWO);
`else
  assign acc     = xfer;
  assign acc_val = (cfg_ratio < TWO) ? TWO : cfg_ratio;
  assign err_d   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    case (state_q)
      IDLE: begin
        if (acc) ratio_d = acc_val;
        cnt_d = '0;
        clk_d = run;
        if (run) state_d = RUN;
      end
      RUN, PEND: begin
        if (boundary) begin
          cnt_d   = '0;
          clk_d   = run;
          state_d = run ? RUN : IDLE;
          if (state_q == PEND) ratio_d = pend_q;
        end else begin
          cnt_d = cnt_q + ONE;
          clk_d = ((cnt_q + ONE) < (ratio_q >> 1));
        end
        // A ratio arriving on the final boundary has no later period to wait for.
        if (acc) begin
          if (boundary && !run) begin
            ratio_d = acc_val;
          end else begin
            pend_d  = acc_val;
            state_d = PEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
    tick_d = (state_d != IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ratio_q <= INIT;
      pend_q  <= INIT;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign clk_out     = clk_q;
  assign period_tick = tick_q;
  assign cur_ratio   = ratio_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios then random traffic against a period/phase reference model.
module tb_clk_div_ctrl;
  localparam int CNT_W    = 8;
  localparam int DIV_INIT = 8;

  logic             clk_100 = 1'b0;
  logic             rst_n, run, cfg_valid;
  logic [CNT_W-1:0] cfg_ratio;
  logic             cfg_ready, clk_out, period_tick, cfg_err;
  logic [CNT_W-1:0] cur_ratio;

  int tests = 0;
  int fails = 0;

  // Reference model: a running flag, phase within the period, ratio in force, queue of waiting ratios.
  bit m_running;
  int m_pos;
  int m_ratio;
  int m_pend[$];
  bit m_err;

  always #5 clk_100 = ~clk_100;

  clk_div_ctrl #(.CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
    .clk_100    (clk_100),
    .rst_n      (rst_n),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_ratio  (cfg_ratio),
    .cfg_ready  (cfg_ready),
    .clk_out    (clk_out),
    .period_tick(period_tick),
    .cur_ratio  (cur_ratio),
    .cfg_err    (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 0;
    m_pos     = 0;
    m_ratio   = DIV_INIT;
    m_pend.delete();
    m_err     = 0;
  endtask

  task automatic model_step(input bit r_run, input bit v, input int r);
    bit acc;
    int val;
    acc   = 0;
    val   = 0;
    m_err = 0;
    if (v && m_pend.size() == 0) begin
`ifdef CLK_DIV_CFG_CHK_EN
      if (r < 2) m_err = 1;
      else begin acc = 1; val = r; end
`else
      acc = 1;
      val = (r < 2) ? 2 : r;
`endif
    end
    if (!m_running) begin
      if (acc) m_ratio = val;
      if (r_run) begin m_running = 1; m_pos = 0; end
    end else begin
      if (m_pos == m_ratio - 1) begin
        if (m_pend.size() > 0) m_ratio = m_pend.pop_front();
        m_pos = 0;
        if (!r_run) m_running = 0;
      end else begin
        m_pos++;
      end
      if (acc) begin
        if (m_running) m_pend.push_back(val);
        else m_ratio = val;
      end
    end
  endtask

  task automatic check_all();
    chk("clk_out",     clk_out,     32'(m_running && (m_pos < m_ratio / 2)));
    chk("period_tick", period_tick, 32'(m_running && (m_pos == 0)));
    chk("cfg_ready",   cfg_ready,   32'(m_pend.size() == 0));
    chk("cur_ratio",   cur_ratio,   32'(m_ratio));
    chk("cfg_err",     cfg_err,     32'(m_err));
  endtask

  // Called at a falling edge; outputs are checked at the next falling edge.
  task automatic step(input bit s_run, input bit v, input int ratio);
    run       = s_run;
    cfg_valid = v;
    cfg_ratio = ratio[CNT_W-1:0];
    @(posedge clk_100);
    model_step(s_run, v, ratio);
    @(negedge clk_100);
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    @(negedge clk_100);
    check_all();
    rst_n = 1;
  endtask

  task automatic stop_idle();
    for (int i = 0; i < 300 && m_running; i++) step(0, 0, 0);
    chk("reached_idle", {31'b0, clk_out}, 32'(0));
  endtask

  initial begin
    rst_n     = 0;
    run       = 0;
    cfg_valid = 0;
    cfg_ratio = '0;
    model_reset();
    @(negedge clk_100);
    check_all();
    rst_n = 1;

    // Default ratio: 4 high / 4 low, first tick right after run is sampled.
    repeat (20) step(1, 0, 0);

    // Drop run at cnt=1: period completes then idle with no further tick.
    for (int i = 0; i < 20 && m_pos != 1; i++) step(1, 0, 0);
    repeat (12) step(0, 0, 0);
    chk("idle_clk_out", clk_out, 32'(0));
    chk("idle_tick", period_tick, 32'(0));

    // Ratio 5 loaded in idle, then run.
    step(0, 1, 5);
    chk("idle_load_5", cur_ratio, 32'(5));
    repeat (16) step(1, 0, 0);

    // Back to 8, then offer 4 at cnt=2.
    stop_idle();
    step(0, 1, 8);
    for (int i = 0; i < 20 && !(m_running && m_pos == 2); i++) step(1, 0, 0);
    step(1, 1, 4);
    chk("pend_not_ready", cfg_ready, 32'(0));
    chk("pend_ratio_kept", cur_ratio, 32'(8));
    repeat (20) step(1, 0, 0);

    // Ratio below 2.
    stop_idle();
    step(0, 1, 1);
`ifdef CLK_DIV_CFG_CHK_EN
    chk("low_ratio_err", cfg_err, 32'(1));
    chk("low_ratio_kept", cur_ratio, 32'(4));
`else
    chk("low_ratio_clamp", cur_ratio, 32'(2));
    chk("low_ratio_err0", cfg_err, 32'(0));
`endif
    repeat (8) step(1, 0, 0);

    // Asynchronous reset at cnt=3 with a ratio pending.
    stop_idle();
    step(0, 1, 8);
    for (int i = 0; i < 20 && !(m_running && m_pos == 1); i++) step(1, 0, 0);
    step(1, 1, 5);
    step(1, 0, 0);
    chk("pre_reset_cnt3_pending", cfg_ready, 32'(0));
    do_reset();
    chk("post_reset_ratio", cur_ratio, 32'(DIV_INIT));
    repeat (20) step(1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 12, int'($urandom_range(0, 12)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
